// File: rtl/fifo_pkg.sv
// Shared constants for the sync FIFO and its stream drain logic.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH    = 16;
    localparam int unsigned FIFO_DEPTH    = 8;
    localparam int unsigned BURST_LEN_DEF = 4;
    localparam int unsigned BEAT_W_DEF    = 8;
    localparam int unsigned BUF_DEPTH     = 3;
    localparam int unsigned BUF_PTR_W     = 2;
    localparam int unsigned BUF_CNT_W     = 2;

    // Advance a circular-buffer pointer, wrapping at BUF_DEPTH.
    function automatic logic [BUF_PTR_W-1:0] buf_ptr_inc(input logic [BUF_PTR_W-1:0] p);
        return (p == BUF_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + BUF_PTR_W'(1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Three-entry circular elastic buffer with push/pop/clear, head data and occupancy.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     push_data_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     head_data_o,
    output logic [BUF_CNT_W-1:0] count_o
);

    logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
    logic [WIDTH-1:0]     mem_d [BUF_DEPTH];
    logic [BUF_PTR_W-1:0] head_q, head_d;
    logic [BUF_PTR_W-1:0] tail_q, tail_d;
    logic [BUF_CNT_W-1:0] count_q, count_d;

    // Clear wins over any same-cycle push or pop.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                mem_d[tail_q] = push_data_i;
                tail_d        = buf_ptr_inc(tail_q);
            end
            if (pop_i) begin
                head_d = buf_ptr_inc(head_q);
            end
            count_d = count_q + BUF_CNT_W'(push_i) - BUF_CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign count_o     = count_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// FIFO read port to valid/ready stream converter with burst framing.
// Optional burst statistics output enabled by FIFO_STREAM_STATS_EN.
module fifo_stream_drain
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF,
    parameter int unsigned BEAT_W    = BEAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
`ifdef FIFO_STREAM_STATS_EN
    ,
    output logic [15:0]      burst_count
`endif
);

    localparam int unsigned OCC_W = BUF_CNT_W + 1;

    logic                 active_q;
    logic                 inflight_q;
    logic                 discard_q, discard_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [BUF_CNT_W-1:0] buf_count;
    logic [OCC_W-1:0]     occupancy;
    logic                 push;
    logic                 handshake;
    logic                 beat_last;

    // Issue depends only on registered state, fifo_empty and flush.
    assign occupancy  = OCC_W'(buf_count) + OCC_W'(inflight_q);
    assign fifo_rd_en = active_q && !fifo_empty && !flush && (occupancy < OCC_W'(BUF_DEPTH));

    assign push      = inflight_q && !discard_q && !flush;
    assign out_valid = (buf_count != '0);
    assign handshake = out_valid && out_ready;
    assign beat_last = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign out_last  = out_valid && beat_last;

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (flush),
        .push_i      (push),
        .push_data_i (fifo_rd_data),
        .pop_i       (handshake),
        .head_data_o (out_data),
        .count_o     (buf_count)
    );

    always_comb begin
        beat_d    = beat_q;
        discard_d = flush && inflight_q;
        if (flush) begin
            beat_d = '0;
        end else if (handshake) begin
            beat_d = beat_last ? '0 : beat_q + BEAT_W'(1);
        end
    end

    // active_q keeps issue off during reset and for one cycle after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            beat_q     <= '0;
        end else begin
            active_q   <= 1'b1;
            inflight_q <= fifo_rd_en;
            discard_q  <= discard_d;
            beat_q     <= beat_d;
        end
    end

`ifdef FIFO_STREAM_STATS_EN
    logic [15:0] burst_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_count_q <= '0;
        end else if (handshake && out_last) begin
            burst_count_q <= burst_count_q + 16'd1;
        end
    end

    assign burst_count = burst_count_q;
`endif

endmodule
